// File: rtl/clkmon_pkg.sv
// -----------------------------------------------------------------------------
// clkmon_pkg
// Shared types and constants for the divided-clock monitor.
//   clkmon_state_e   : monitor FSM states (SYNC, MEAS, LOCK)
//   clkmon_timeout() : saturation / timeout value of a CW-bit half-cycle counter
// Optional build macro used by the monitor: CLKMON_ERRCNT_EN (error counter).
// -----------------------------------------------------------------------------
package clkmon_pkg;

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      MEAS = 2'd1,
      LOCK = 2'd2
   } clkmon_state_e;

   function automatic int unsigned clkmon_timeout(input int unsigned cw);
      return (32'd1 << cw) - 32'd1;
   endfunction

endpackage

// File: rtl/clkdiv_monitor_if.sv
// -----------------------------------------------------------------------------
// clkdiv_monitor_if
// Bundles the divided clock under test and the monitor's measurement results.
//   f_in        : divided clock under test (driven by the master side)
//   period_hc   : last measured period, half-cycles
//   high_hc     : last measured high time, half-cycles
//   meas_valid  : one-cycle pulse, new period_hc/high_hc pair
//   ratio_err   : one-cycle pulse, wrong period or timeout
//   duty_err    : one-cycle pulse, duty outside tolerance
//   locked      : level, enough consecutive good periods
//   err_cnt     : saturating error count (only with CLKMON_ERRCNT_EN)
// Modports: master = divider / observer side, slave = monitor.
// -----------------------------------------------------------------------------
interface clkdiv_monitor_if #(
   parameter int CW = 8
);
   logic          f_in;
   logic [CW-1:0] period_hc;
   logic [CW-1:0] high_hc;
   logic          meas_valid;
   logic          ratio_err;
   logic          duty_err;
   logic          locked;
`ifdef CLKMON_ERRCNT_EN
   logic [15:0]   err_cnt;
`endif

   modport master (
      output f_in,
`ifdef CLKMON_ERRCNT_EN
      input  err_cnt,
`endif
      input  period_hc, high_hc, meas_valid, ratio_err, duty_err, locked
   );

   modport slave (
      input  f_in,
`ifdef CLKMON_ERRCNT_EN
      output err_cnt,
`endif
      output period_hc, high_hc, meas_valid, ratio_err, duty_err, locked
   );

endinterface

// File: rtl/clkmon_edge_sampler.sv
// -----------------------------------------------------------------------------
// clkmon_edge_sampler
// Turns f_in into two ordered half-cycle samples per clk cycle and flags rising
// edges in each. smp0 is f_in captured on the falling clk edge (first half of
// the cycle), smp1 is f_in as seen at the rising edge (second half).
//   clk, rst : system clock (both edges used), async active-high reset
//   f_i      : divided clock under test
//   smp0_o   : first-half sample
//   smp1_o   : second-half sample
//   rise0_o  : rising edge at smp0 (relative to previous cycle's smp1)
//   rise1_o  : rising edge at smp1 (relative to smp0)
// -----------------------------------------------------------------------------
module clkmon_edge_sampler (
   input  logic clk,
   input  logic rst,
   input  logic f_i,
   output logic smp0_o,
   output logic smp1_o,
   output logic rise0_o,
   output logic rise1_o
);

   logic s_neg_q;
   logic prev_q;

   always_ff @(negedge clk or posedge rst) begin
      if (rst) s_neg_q <= 1'b0;
      else     s_neg_q <= f_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= 1'b0;
      else     prev_q <= f_i;
   end

   assign smp0_o  = s_neg_q;
   assign smp1_o  = f_i;
   assign rise0_o = s_neg_q & ~prev_q;
   assign rise1_o = f_i & ~s_neg_q;

endmodule

// File: rtl/clkdiv_monitor.sv
// -----------------------------------------------------------------------------
// clkdiv_monitor
// Measures period and high time of a divided clock at half-cycle resolution and
// checks them against the expected ratio and duty tolerance; asserts locked
// after LOCK_N consecutive good periods.
//   clk  : system clock, both edges used
//   rst  : asynchronous, active-high reset
//   bus  : clkdiv_monitor_if.slave (f_in in; results out)
// Optional: define CLKMON_ERRCNT_EN to add bus.err_cnt, a saturating count of
// cycles carrying ratio_err or duty_err.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   SYNC  | waiting for the first rising edge; nothing is published
//   MEAS  | measuring periods, fewer than LOCK_N consecutive good ones
//   LOCK  | measuring periods, locked indication asserted
// -----------------------------------------------------------------------------
module clkdiv_monitor
   import clkmon_pkg::*;
#(
   parameter int EXP_DIV  = 5,
   parameter int CW       = 8,
   parameter int DUTY_TOL = 1,
   parameter int LOCK_N   = 3
) (
   input  logic             clk,
   input  logic             rst,
   clkdiv_monitor_if.slave  bus
);

   localparam int              CW1      = CW + 1;
   localparam int              GW       = $clog2(LOCK_N + 1);
   localparam logic [CW-1:0]   HC_MAX   = CW'(clkmon_timeout(CW));
   localparam logic [CW-1:0]   HC_EXP   = CW'(2 * EXP_DIV);
   localparam logic [CW:0]     TOL      = CW1'(DUTY_TOL);
   localparam logic [GW-1:0]   GOOD_MAX = GW'(LOCK_N);

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == HC_MAX) ? v : v + 1'b1;
   endfunction

   logic [1:0] smp;
   logic [1:0] rise;

   clkmon_edge_sampler u_sampler (
      .clk     (clk),
      .rst     (rst),
      .f_i     (bus.f_in),
      .smp0_o  (smp[0]),
      .smp1_o  (smp[1]),
      .rise0_o (rise[0]),
      .rise1_o (rise[1])
   );

   clkmon_state_e   state_q, state_d;
   logic [CW-1:0]   tot_q, tot_d;
   logic [CW-1:0]   hi_q, hi_d;
   logic [GW-1:0]   good_q, good_d;
   logic [CW-1:0]   period_q, high_q;
   logic            mv_q, ratio_q, duty_q, locked_q;

   logic            act;
   logic            pub;
   logic [CW-1:0]   tot, hi;
   logic [CW-1:0]   pub_tot, pub_hi;
   logic signed [CW:0] diff;
   logic [CW:0]     diff_abs;
   logic            mv_d, ratio_d, duty_d;

   always_comb begin
      state_d  = state_q;
      good_d   = good_q;
      tot      = tot_q;
      hi       = hi_q;
      act      = (state_q != SYNC);
      pub      = 1'b0;
      pub_tot  = '0;
      pub_hi   = '0;
      mv_d     = 1'b0;
      ratio_d  = 1'b0;
      duty_d   = 1'b0;
      diff     = '0;
      diff_abs = '0;

      // Two half-samples per cycle, oldest first. At most one of them can be a
      // rising edge, so at most one period closes per cycle. A rising edge
      // restarts both counters at 1 because the edge sample itself is high.
      for (int k = 0; k < 2; k++) begin
         if (rise[k]) begin
            if (act) begin
               pub     = 1'b1;
               pub_tot = tot;
               pub_hi  = hi;
            end
            act = 1'b1;
            tot = CW'(1);
            hi  = CW'(1);
         end else if (act) begin
            tot = sat_inc(tot);
            if (smp[k]) hi = sat_inc(hi);
         end
      end

      // Wrap-around in CW+1 bits is harmless: the true difference lies in
      // [-period, +period] and period never exceeds HC_MAX.
      diff     = {pub_hi, 1'b0} - {1'b0, pub_tot};
      diff_abs = diff[CW] ? $unsigned(-diff) : $unsigned(diff);

      if (pub) begin
         mv_d    = 1'b1;
         ratio_d = (pub_tot != HC_EXP);
         duty_d  = (diff_abs > TOL);
         if (ratio_d || duty_d) begin
            good_d  = '0;
            state_d = MEAS;
         end else begin
            if (good_q != GOOD_MAX) good_d = good_q + 1'b1;
            state_d = (good_d == GOOD_MAX) ? LOCK : MEAS;
         end
      end else if (state_q == SYNC) begin
         if (act) state_d = MEAS;
      end else if (tot == HC_MAX) begin
         ratio_d = 1'b1;
         good_d  = '0;
         state_d = SYNC;
         tot     = '0;
         hi      = '0;
      end

      tot_d = tot;
      hi_d  = hi;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= SYNC;
         tot_q    <= '0;
         hi_q     <= '0;
         good_q   <= '0;
         period_q <= '0;
         high_q   <= '0;
         mv_q     <= 1'b0;
         ratio_q  <= 1'b0;
         duty_q   <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tot_q    <= tot_d;
         hi_q     <= hi_d;
         good_q   <= good_d;
         mv_q     <= mv_d;
         ratio_q  <= ratio_d;
         duty_q   <= duty_d;
         // Follows the state one cycle late, so locked drops the cycle after
         // the error pulse that left LOCK.
         locked_q <= (state_q == LOCK);
         if (pub) begin
            period_q <= pub_tot;
            high_q   <= pub_hi;
         end
      end
   end

   assign bus.period_hc  = period_q;
   assign bus.high_hc    = high_q;
   assign bus.meas_valid = mv_q;
   assign bus.ratio_err  = ratio_q;
   assign bus.duty_err   = duty_q;
   assign bus.locked     = locked_q;

`ifdef CLKMON_ERRCNT_EN
   logic [15:0] err_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else if ((ratio_d || duty_d) && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign bus.err_cnt = err_cnt_q;
`endif

endmodule
